// File: rtl/param_shift_register_if.sv
// Bus bundle for param_shift_register: control and data inputs plus register state outputs.
// The master drives operations and the slave (the register) returns its state.
interface param_shift_register_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d_par;
    logic             sin_msb;
    logic             sin_lsb;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             sout_lsb;
    logic             sout_msb;
    logic [CW-1:0]    shift_cnt;
    logic             shift_done;

    modport master (
        output en, mode, d_par, sin_msb, sin_lsb,
        input  q, qbar, sout_lsb, sout_msb, shift_cnt, shift_done
    );

    modport slave (
        input  en, mode, d_par, sin_msb, sin_lsb,
        output q, qbar, sout_lsb, sout_msb, shift_cnt, shift_done
    );
endinterface

// File: rtl/param_shift_register.sv
// WIDTH-bit universal shift register: parallel load, shift/rotate both ways, clear, invert,
// with a saturating count of shifts since the last load or clear.
module param_shift_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    param_shift_register_if.slave bus
);
    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_LOAD   = 3'b001;
    localparam logic [2:0] MODE_SHR    = 3'b010;
    localparam logic [2:0] MODE_SHL    = 3'b011;
    localparam logic [2:0] MODE_ROR    = 3'b100;
    localparam logic [2:0] MODE_ROL    = 3'b101;
    localparam logic [2:0] MODE_CLEAR  = 3'b110;
    localparam logic [2:0] MODE_INVERT = 3'b111;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic [CW-1:0]    cnt_inc_s;

    // Saturating increment used by every shift and rotate.
    always_comb begin
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Next-state selection for the data word and shift counter.
    always_comb begin
        q_nxt_s   = q_r;
        cnt_nxt_s = cnt_r;
        if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: begin
                    q_nxt_s   = q_r;
                    cnt_nxt_s = cnt_r;
                end
                MODE_LOAD: begin
                    q_nxt_s   = bus.d_par;
                    cnt_nxt_s = '0;
                end
                MODE_SHR: begin
                    q_nxt_s   = {bus.sin_msb, q_r[WIDTH-1:1]};
                    cnt_nxt_s = cnt_inc_s;
                end
                MODE_SHL: begin
                    q_nxt_s   = {q_r[WIDTH-2:0], bus.sin_lsb};
                    cnt_nxt_s = cnt_inc_s;
                end
                MODE_ROR: begin
                    q_nxt_s   = {q_r[0], q_r[WIDTH-1:1]};
                    cnt_nxt_s = cnt_inc_s;
                end
                MODE_ROL: begin
                    q_nxt_s   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                    cnt_nxt_s = cnt_inc_s;
                end
                MODE_CLEAR: begin
                    q_nxt_s   = '0;
                    cnt_nxt_s = '0;
                end
                MODE_INVERT: begin
                    q_nxt_s   = ~q_r;
                    cnt_nxt_s = cnt_r;
                end
                default: begin
                    q_nxt_s   = q_r;
                    cnt_nxt_s = cnt_r;
                end
            endcase
        end else begin
            q_nxt_s   = q_r;
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers; reset takes effect immediately without a clock edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            q_r   <= RESET_VALUE;
            cnt_r <= '0;
        end else begin
            q_r   <= q_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    // Derived outputs are pure functions of registered state, so they track q with no lag.
    assign bus.q          = q_r;
    assign bus.qbar       = ~q_r;
    assign bus.sout_lsb   = q_r[0];
    assign bus.sout_msb   = q_r[WIDTH-1];
    assign bus.shift_cnt  = cnt_r;
    assign bus.shift_done = (cnt_r == CNT_MAX);
endmodule

// File: tb/tb_param_shift_register.sv
// Self-checking bench for param_shift_register (WIDTH=8): directed scenarios plus random
// operations compared against an arithmetic reference model.
module tb_param_shift_register;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [7:0] ref_q;
    int         ref_cnt;

    param_shift_register_if #(.WIDTH(W)) bus ();
    param_shift_register_if #(.WIDTH(W)) bus_a5 ();

    param_shift_register #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    param_shift_register #(.WIDTH(W), .RESET_VALUE(8'hA5)) dut_a5 (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus_a5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode must be known whenever the register is enabled
    assert property (@(posedge clk) disable iff (!rst_n) bus.en |-> !$isunknown(bus.mode));

    // Reference behaviour written from the operation table with plain arithmetic.
    task automatic model_op(input logic [2:0] m, input logic [7:0] d, input logic sm, input logic sl);
        int v;
        v = ref_q;
        case (m)
            3'd1: begin v = d; ref_cnt = 0; end
            3'd2: begin v = (v / 2) + (sm ? 128 : 0); ref_cnt = (ref_cnt < W) ? ref_cnt + 1 : W; end
            3'd3: begin v = ((v * 2) % 256) + (sl ? 1 : 0); ref_cnt = (ref_cnt < W) ? ref_cnt + 1 : W; end
            3'd4: begin v = (v / 2) + ((v % 2) * 128); ref_cnt = (ref_cnt < W) ? ref_cnt + 1 : W; end
            3'd5: begin v = ((v * 2) % 256) + (v / 128); ref_cnt = (ref_cnt < W) ? ref_cnt + 1 : W; end
            3'd6: begin v = 0; ref_cnt = 0; end
            3'd7: begin v = 255 - v; end
            default: begin end
        endcase
        ref_q = v[7:0];
    endtask

    task automatic model_reset();
        ref_q   = 8'h00;
        ref_cnt = 0;
    endtask

    // Drive one operation, clock it, and advance the model; sampling happens #1 after the edge.
    task automatic drive_cycle(input logic e, input logic [2:0] m, input logic [7:0] d,
                               input logic sm, input logic sl);
        bus.en      = e;
        bus.mode    = m;
        bus.d_par   = d;
        bus.sin_msb = sm;
        bus.sin_lsb = sl;
        @(posedge clk);
        #1;
        if (rst_n && e) model_op(m, d, sm, sl);
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 3'd1, 8'hFF, 1'b0, 1'b0);
        drive_cycle(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (bus.q !== 8'h00 || bus.qbar !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_q: got q=%h qbar=%h, want q=00 qbar=ff", bus.q, bus.qbar);
        end
        n_checks++;
        if (bus.shift_cnt !== 4'd0 || bus.shift_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cnt: got cnt=%0d done=%b, want 0/0", bus.shift_cnt, bus.shift_done);
        end
        n_checks++;
        if (bus_a5.q !== 8'hA5 || bus_a5.qbar !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_value_a5: got q=%h qbar=%h, want a5/5a", bus_a5.q, bus_a5.qbar);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_shr();
        logic [7:0] exp_bits;
        exp_bits = 8'b1011_0100;
        drive_cycle(1'b1, 3'd1, 8'hB4, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus.sout_lsb !== exp_bits[i]) begin
                n_fail++;
                $display("FAIL shr_sout_lsb[%0d]: got %b, want %b", i, bus.sout_lsb, exp_bits[i]);
            end
            drive_cycle(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
        end
        n_checks++;
        if (bus.q !== 8'h00 || bus.shift_cnt !== 4'd8 || bus.shift_done !== 1'b1) begin
            n_fail++;
            $display("FAIL shr_final: got q=%h cnt=%0d done=%b, want 00/8/1", bus.q, bus.shift_cnt, bus.shift_done);
        end
        drive_cycle(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (bus.shift_cnt !== 4'd8 || bus.shift_done !== 1'b1) begin
            n_fail++;
            $display("FAIL shr_saturate: got cnt=%0d done=%b, want 8/1", bus.shift_cnt, bus.shift_done);
        end
    endtask

    task automatic test_shl();
        logic [7:0] stream;
        stream = 8'b0100_1101;
        drive_cycle(1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 3'd3, 8'h00, 1'b0, stream[i]);
        end
        n_checks++;
        if (bus.q !== 8'hB2 || bus.shift_done !== 1'b1) begin
            n_fail++;
            $display("FAIL shl_final: got q=%h done=%b, want b2/1", bus.q, bus.shift_done);
        end
        drive_cycle(1'b1, 3'd1, 8'h77, 1'b0, 1'b0);
        n_checks++;
        if (bus.shift_cnt !== 4'd0 || bus.shift_done !== 1'b0 || bus.q !== 8'h77) begin
            n_fail++;
            $display("FAIL shl_reload: got q=%h cnt=%0d done=%b, want 77/0/0", bus.q, bus.shift_cnt, bus.shift_done);
        end
    endtask

    task automatic test_rotate_invert_clear();
        drive_cycle(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
        drive_cycle(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (bus.q !== 8'h03) begin
            n_fail++;
            $display("FAIL rol: got q=%h, want 03", bus.q);
        end
        drive_cycle(1'b1, 3'd4, 8'hFF, 1'b0, 1'b1);
        drive_cycle(1'b1, 3'd4, 8'hFF, 1'b0, 1'b1);
        n_checks++;
        if (bus.q !== 8'hC0) begin
            n_fail++;
            $display("FAIL ror: got q=%h, want c0", bus.q);
        end
        drive_cycle(1'b1, 3'd7, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (bus.q !== 8'h3F || bus.qbar !== 8'hC0 || bus.shift_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL invert: got q=%h qbar=%h cnt=%0d, want 3f/c0/3", bus.q, bus.qbar, bus.shift_cnt);
        end
        drive_cycle(1'b1, 3'd6, 8'hFF, 1'b1, 1'b1);
        n_checks++;
        if (bus.q !== 8'h00 || bus.shift_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL clear: got q=%h cnt=%0d, want 00/0", bus.q, bus.shift_cnt);
        end
    endtask

    task automatic test_enable_hold();
        drive_cycle(1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
        drive_cycle(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
        drive_cycle(1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
        for (int m = 0; m < 8; m++) begin
            drive_cycle(1'b0, m[2:0], 8'($urandom), 1'($urandom), 1'($urandom));
            n_checks++;
            if (bus.q !== 8'h5A || bus.shift_cnt !== 4'd2) begin
                n_fail++;
                $display("FAIL en_hold mode=%0d: got q=%h cnt=%0d, want 5a/2", m, bus.q, bus.shift_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        drive_cycle(1'b1, 3'd1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 3'd2, 8'h00, 1'($urandom), 1'b0);
            if (i == 1) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                n_checks++;
                if (bus.q !== 8'h00 || bus.shift_cnt !== 4'd0 || bus_a5.q !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL burst_reset: got q=%h cnt=%0d q_a5=%h, want 00/0/a5", bus.q, bus.shift_cnt, bus_a5.q);
                end
            end
        end
        n_checks++;
        if (bus.q !== 8'h00 || bus.shift_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL burst_held_in_reset: got q=%h cnt=%0d, want 00/0", bus.q, bus.shift_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
        n_checks++;
        if (bus.q !== 8'h3C || bus.shift_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset_load: got q=%h cnt=%0d, want 3c/0", bus.q, bus.shift_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_qbar;
        for (int i = 0; i < 300; i++) begin
            drive_cycle(($urandom_range(0, 7) != 0), 3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            exp_qbar = 8'hFF ^ ref_q;
            n_checks++;
            if (bus.q !== ref_q || bus.qbar !== exp_qbar || bus.sout_lsb !== ref_q[0] || bus.sout_msb !== ref_q[7]) begin
                n_fail++;
                $display("FAIL random_q[%0d]: got q=%h qbar=%h lsb=%b msb=%b, want q=%h", i, bus.q, bus.qbar,
                         bus.sout_lsb, bus.sout_msb, ref_q);
            end
            n_checks++;
            if (int'(bus.shift_cnt) != ref_cnt || bus.shift_done !== (ref_cnt == W)) begin
                n_fail++;
                $display("FAIL random_cnt[%0d]: got cnt=%0d done=%b, want cnt=%0d", i, bus.shift_cnt,
                         bus.shift_done, ref_cnt);
            end
        end
    endtask

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.en = 1'b0; bus.mode = 3'd0; bus.d_par = 8'h00; bus.sin_msb = 1'b0; bus.sin_lsb = 1'b0;
        bus_a5.en = 1'b0; bus_a5.mode = 3'd0; bus_a5.d_par = 8'h00; bus_a5.sin_msb = 1'b0; bus_a5.sin_lsb = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_shr();
        test_shl();
        test_rotate_invert_clear();
        test_enable_hold();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
